phase_unwrap_decim: RTL and testbench



---
 rtl/phase_unwrap_decim_pkg.sv | 21 ++
 rtl/phase_unwrap_decim_if.sv | 31 +++
 rtl/phase_unwrap_decim_delta.sv | 82 ++++++++
 rtl/phase_unwrap_decim.sv | 118 +++++++++++
 tb/tb_phase_unwrap_decim.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/phase_unwrap_decim_pkg.sv
// Shared constants and width helpers for the phase unwrap / decimation slice.
package phase_pkg;

  localparam int unsigned PHASE_BITS_DEF = 16;
  localparam int unsigned ACC_BITS_DEF   = 48;

  // One full turn in phase LSBs for the default phase width.
  localparam longint unsigned TURN_SCALE = 64'd1 << PHASE_BITS_DEF;

  // A window sum of DECIM deltas, each within half a turn, fits in this many bits.
  function automatic int unsigned freq_bits(input int unsigned phase_bits,
                                            input int unsigned decim);
    return phase_bits + $clog2(decim);
  endfunction

  // Decimation counter width; DECIM = 1 still needs one bit to hold zero.
  function automatic int unsigned cnt_bits(input int unsigned decim);
    return (decim > 1) ? $clog2(decim) : 1;
  endfunction

endpackage

// File: rtl/phase_unwrap_decim_if.sv
// Sample-in / window-out bundle between the CORDIC stage and the servo readout.
interface phase_unwrap_decim_if #(
  parameter int unsigned PHASE_BITS     = 16,
  parameter int unsigned AMPLITUDE_BITS = 14,
  parameter int unsigned ACC_BITS       = 48,
  parameter int unsigned FREQ_BITS      = 20
);

  logic                             in_valid;
  logic signed [PHASE_BITS-1:0]     phase_in;
  logic signed [AMPLITUDE_BITS-1:0] mag_in;
  logic                             clear;

  logic                             out_valid;
  logic signed [ACC_BITS-1:0]       phase_unwrapped;
  logic signed [FREQ_BITS-1:0]      freq_sum;
  logic                             low_mag;
  logic                             slip;
  logic                             overflow;

  modport master (
    output in_valid, phase_in, mag_in, clear,
    input  out_valid, phase_unwrapped, freq_sum, low_mag, slip, overflow
  );

  modport slave (
    input  in_valid, phase_in, mag_in, clear,
    output out_valid, phase_unwrapped, freq_sum, low_mag, slip, overflow
  );

endinterface

// File: rtl/phase_unwrap_decim_delta.sv
// Stage 1: magnitude gate, priming and modulo phase difference.
module phase_delta
  import phase_pkg::*;
#(
  parameter int unsigned PHASE_BITS     = PHASE_BITS_DEF,
  parameter int unsigned AMPLITUDE_BITS = 14,
  parameter int          MAG_MIN        = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic signed [PHASE_BITS-1:0]     phase_in,
  input  logic signed [AMPLITUDE_BITS-1:0] mag_in,
  output logic                             delta_valid,
  output logic signed [PHASE_BITS-1:0]     delta,
  output logic                             low_mag,
  output logic                             slip
);

  localparam logic signed [AMPLITUDE_BITS-1:0] MagThr = AMPLITUDE_BITS'(MAG_MIN);

  logic                         primed_q, primed_d;
  logic signed [PHASE_BITS-1:0] prev_q, prev_d;
  logic signed [PHASE_BITS-1:0] delta_q, delta_d;
  logic                         dv_q, dv_d;
  logic                         low_q, low_d;
  logic                         slip_q, slip_d;
  logic                         good;

  // Signed compare: a negative magnitude counts as signal loss.
  assign good = in_valid && (mag_in >= MagThr);

  // Next state: good samples emit a delta (zero when re-priming), low samples unprime.
  always_comb begin
    primed_d = primed_q;
    prev_d   = prev_q;
    delta_d  = delta_q;
    dv_d     = 1'b0;
    low_d    = low_q;
    slip_d   = slip_q;
    if (in_valid) begin
      prev_d = phase_in;
      if (good) begin
        dv_d     = 1'b1;
        low_d    = 1'b0;
        primed_d = 1'b1;
        // Natural PHASE_BITS wrap gives the shortest signed step.
        delta_d  = primed_q ? (phase_in - prev_q) : '0;
      end else begin
        low_d    = 1'b1;
        primed_d = 1'b0;
        if (primed_q) slip_d = 1'b1;
      end
    end
  end

  // Stage 1 registers with synchronous reset / soft clear.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      primed_q <= 1'b0;
      prev_q   <= '0;
      delta_q  <= '0;
      dv_q     <= 1'b0;
      low_q    <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      primed_q <= primed_d;
      prev_q   <= prev_d;
      delta_q  <= delta_d;
      dv_q     <= dv_d;
      low_q    <= low_d;
      slip_q   <= slip_d;
    end
  end

  assign delta_valid = dv_q;
  assign delta       = delta_q;
  assign low_mag     = low_q;
  assign slip        = slip_q;

endmodule

// File: rtl/phase_unwrap_decim.sv
// Phase unwrapper with windowed frequency integration and decimated output.
module phase_unwrap_decim
  import phase_pkg::*;
#(
  parameter int unsigned PHASE_BITS     = PHASE_BITS_DEF,
  parameter int unsigned AMPLITUDE_BITS = 14,
  parameter int unsigned ACC_BITS       = ACC_BITS_DEF,
  parameter int unsigned DECIM          = 16,
  parameter int          MAG_MIN        = 64
) (
  input logic                 clk,
  input logic                 rst,
  phase_unwrap_decim_if.slave bus
);

  localparam int unsigned FREQ_BITS = freq_bits(PHASE_BITS, DECIM);
  localparam int unsigned CNT_BITS  = cnt_bits(DECIM);
  localparam logic [CNT_BITS-1:0] CntLast = CNT_BITS'(DECIM - 1);

  logic                         d_valid;
  logic signed [PHASE_BITS-1:0] delta;
  logic                         low_mag;
  logic                         slip;

  phase_delta #(
    .PHASE_BITS    (PHASE_BITS),
    .AMPLITUDE_BITS(AMPLITUDE_BITS),
    .MAG_MIN       (MAG_MIN)
  ) u_delta (
    .clk        (clk),
    .rst        (rst),
    .clear      (bus.clear),
    .in_valid   (bus.in_valid),
    .phase_in   (bus.phase_in),
    .mag_in     (bus.mag_in),
    .delta_valid(d_valid),
    .delta      (delta),
    .low_mag    (low_mag),
    .slip       (slip)
  );

  logic signed [ACC_BITS-1:0]  acc_q, acc_d;
  logic signed [FREQ_BITS-1:0] win_q, win_d;
  logic [CNT_BITS-1:0]         cnt_q, cnt_d;
  logic                        ov_q, ov_d;
  logic signed [ACC_BITS-1:0]  pu_q, pu_d;
  logic signed [FREQ_BITS-1:0] fs_q, fs_d;
  logic                        ovf_q, ovf_d;

  logic signed [ACC_BITS-1:0]  delta_acc;
  logic signed [FREQ_BITS-1:0] delta_win;
  logic signed [ACC_BITS-1:0]  acc_sum;
  logic signed [FREQ_BITS-1:0] win_sum;
  logic                        add_ovf;

  // Sign-extending size casts of the signed delta.
  assign delta_acc = ACC_BITS'(delta);
  assign delta_win = FREQ_BITS'(delta);
  assign acc_sum   = acc_q + delta_acc;
  assign win_sum   = win_q + delta_win;
  // Like-signed operands giving a differently signed result means the add wrapped.
  assign add_ovf   = (acc_q[ACC_BITS-1] == delta_acc[ACC_BITS-1]) &&
                     (acc_sum[ACC_BITS-1] != acc_q[ACC_BITS-1]);

  // Next state: integrate each delta, close the window on the DECIM-th one.
  always_comb begin
    acc_d = acc_q;
    win_d = win_q;
    cnt_d = cnt_q;
    ov_d  = 1'b0;
    pu_d  = pu_q;
    fs_d  = fs_q;
    ovf_d = ovf_q;
    if (d_valid) begin
      acc_d = acc_sum;
      if (add_ovf) ovf_d = 1'b1;
      if (cnt_q == CntLast) begin
        ov_d  = 1'b1;
        pu_d  = acc_sum;
        fs_d  = win_sum;
        win_d = '0;
        cnt_d = '0;
      end else begin
        win_d = win_sum;
        cnt_d = cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Stage 2 and output registers; clear also drops any partial window.
  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      acc_q <= '0;
      win_q <= '0;
      cnt_q <= '0;
      ov_q  <= 1'b0;
      pu_q  <= '0;
      fs_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      ov_q  <= ov_d;
      pu_q  <= pu_d;
      fs_q  <= fs_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.out_valid       = ov_q;
  assign bus.phase_unwrapped = pu_q;
  assign bus.freq_sum        = fs_q;
  assign bus.low_mag         = low_mag;
  assign bus.slip            = slip;
  assign bus.overflow        = ovf_q;

endmodule

// File: tb/tb_phase_unwrap_decim.sv
// Randomised and directed bench for phase_unwrap_decim against an arithmetic reference.
module tb_phase_unwrap_decim;
  import phase_pkg::*;

  localparam int unsigned P      = 16;
  localparam int unsigned A      = 14;
  localparam int unsigned ACC    = 48;
  localparam int unsigned ACC_S  = 20;
  localparam int unsigned DECIM  = 16;
  localparam int          MAGMIN = 64;
  localparam int unsigned FB     = freq_bits(P, DECIM);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phase_unwrap_decim_if #(.PHASE_BITS(P), .AMPLITUDE_BITS(A), .ACC_BITS(ACC), .FREQ_BITS(FB))
    bus ();
  phase_unwrap_decim_if #(.PHASE_BITS(P), .AMPLITUDE_BITS(A), .ACC_BITS(ACC_S), .FREQ_BITS(FB))
    bus_s ();

  phase_unwrap_decim #(
    .PHASE_BITS(P), .AMPLITUDE_BITS(A), .ACC_BITS(ACC), .DECIM(DECIM), .MAG_MIN(MAGMIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  phase_unwrap_decim #(
    .PHASE_BITS(P), .AMPLITUDE_BITS(A), .ACC_BITS(ACC_S), .DECIM(DECIM), .MAG_MIN(MAGMIN)
  ) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: true arithmetic values, wrapped explicitly where hardware wraps.
  bit     m_primed;
  longint m_prev;
  int     m_cnt;
  longint m_win, m_acc, m_acc_s;
  bit     m_ovf, m_ovf_s, m_low, m_slip;
  // Window result waiting one cycle before it becomes visible.
  bit     p_ov;
  longint p_pu, p_pu_s, p_fs;
  bit     p_ovf, p_ovf_s;
  // Expected visible outputs after the current edge.
  bit     e_ov;
  longint e_pu, e_pu_s, e_fs;
  bit     e_ovf, e_ovf_s;

  function automatic longint wrap_s(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    longint m    = half * 2;
    longint r    = v % m;
    if (r >= half) r -= m;
    else if (r < -half) r += m;
    return r;
  endfunction

  function automatic bit out_of_range(input longint v, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (v >= half) || (v < -half);
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 0; m_prev = 0; m_cnt = 0; m_win = 0; m_acc = 0; m_acc_s = 0;
    m_ovf = 0; m_ovf_s = 0; m_low = 0; m_slip = 0;
    p_ov = 0; p_pu = 0; p_pu_s = 0; p_fs = 0; p_ovf = 0; p_ovf_s = 0;
    e_ov = 0; e_pu = 0; e_pu_s = 0; e_fs = 0; e_ovf = 0; e_ovf_s = 0;
  endtask

  // One clock: drive inputs, advance, update reference, compare every output.
  task automatic step(input bit v, input longint ph, input longint mg, input bit clr,
                      input bit rstn);
    longint d, s;
    rst            = rstn;
    bus.in_valid   = v;   bus_s.in_valid = v;
    bus.phase_in   = P'(ph); bus_s.phase_in = P'(ph);
    bus.mag_in     = A'(mg); bus_s.mag_in   = A'(mg);
    bus.clear      = clr; bus_s.clear    = clr;
    @(posedge clk);
    #1;
    if (!rstn || clr) begin
      model_reset();
    end else begin
      e_ov = p_ov; e_pu = p_pu; e_pu_s = p_pu_s; e_fs = p_fs; e_ovf = p_ovf; e_ovf_s = p_ovf_s;
      p_ov = 0;
      if (v) begin
        if (wrap_s(mg, A) >= MAGMIN) begin
          d = m_primed ? wrap_s(wrap_s(ph, P) - m_prev, P) : 0;
          m_primed = 1;
          m_low    = 0;
          s = m_acc + d;
          if (out_of_range(s, ACC)) m_ovf = 1;
          m_acc = wrap_s(s, ACC);
          s = m_acc_s + d;
          if (out_of_range(s, ACC_S)) m_ovf_s = 1;
          m_acc_s = wrap_s(s, ACC_S);
          m_win += d;
          m_cnt++;
          if (m_cnt == DECIM) begin
            p_ov = 1; p_pu = m_acc; p_pu_s = m_acc_s; p_fs = m_win;
            m_win = 0; m_cnt = 0;
          end
          p_ovf = m_ovf; p_ovf_s = m_ovf_s;
        end else begin
          m_low = 1;
          if (m_primed) m_slip = 1;
          m_primed = 0;
        end
        m_prev = wrap_s(ph, P);
      end
    end
    chk("out_valid", bus.out_valid, e_ov);
    chk("phase_unwrapped", bus.phase_unwrapped, e_pu);
    chk("freq_sum", bus.freq_sum, e_fs);
    chk("overflow", bus.overflow, e_ovf);
    chk("low_mag", bus.low_mag, m_low);
    chk("slip", bus.slip, m_slip);
    chk("acc20_phase", bus_s.phase_unwrapped, e_pu_s);
    chk("acc20_overflow", bus_s.overflow, e_ovf_s);
  endtask

  task automatic ramp(input longint start, input longint inc, input int n);
    for (int k = 0; k < n; k++) step(1, start + k * inc, 1000, 0, 1);
  endtask

  initial begin
    model_reset();
    // Reset state
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // +1000/sample ramp over three windows
    ramp(0, 1000, 48);
    step(0, 0, 0, 0, 1);
    chk("ramp1000_final", bus.phase_unwrapped, 47000);
    chk("ramp1000_freq", bus.freq_sum, 16000);

    // +30000/sample across the wrap; small accumulator overflows past 524287
    step(0, 0, 0, 1, 1);
    ramp(0, 30000, 32);
    step(0, 0, 0, 0, 1);
    chk("ovf20_sticky", bus_s.overflow, 1);
    chk("ovf48_clear", bus.overflow, 0);

    // -20000/sample ramp
    step(0, 0, 0, 1, 1);
    ramp(5000, -20000, 40);
    step(0, 0, 0, 0, 1);
    chk("ramp_neg_freq", bus.freq_sum, -320000);

    // Signal-loss gap: 4 good, 3 low, then good
    step(0, 0, 0, 1, 1);
    ramp(100, 700, 4);
    for (int k = 0; k < 3; k++) step(1, 5000 + k, 10, 0, 1);
    chk("gap_low_mag", bus.low_mag, 1);
    ramp(9000, -300, 14);
    chk("gap_slip", bus.slip, 1);

    // Clear mid-window with a valid sample, then re-prime
    step(0, 0, 0, 1, 1);
    ramp(0, 2000, 7);
    step(1, 12345, 500, 1, 1);
    chk("clear_out", bus.phase_unwrapped, 0);
    ramp(-4000, 1500, 20);

    // Reset for one cycle mid-stream, then a cold-start sequence
    step(1, 777, 500, 0, 0);
    chk("rst_pu", bus.phase_unwrapped, 0);
    ramp(0, 1000, 20);

    // Randomised stream with invalid cycles, weak/negative magnitudes and clears
    for (int k = 0; k < 600; k++) begin
      step(($urandom % 4) != 0,
           longint'($urandom_range(0, 65535)) - 32768,
           longint'($urandom_range(0, 240)) - 40,
           ($urandom % 64) == 0, ($urandom % 150) != 0);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
